// File: rtl/sprite_fb_blitter_if.sv
// sprite_fb_blitter_if: blit command/status, sprite ROM read port and frame-buffer write port
interface sprite_fb_blitter_if #(parameter int IDX_W = 3);
    logic             start;
    logic [9:0]       pos_x;
    logic [9:0]       pos_y;
    logic             flip_x;
    logic             busy;
    logic             done;
    logic [13:0]      rom_address;
    logic [IDX_W-1:0] rom_q;
    logic             fb_we;
    logic [16:0]      fb_addr;
    logic [IDX_W-1:0] fb_data;

    modport master (
        input  start, pos_x, pos_y, flip_x, rom_q,
        output busy, done, rom_address, fb_we, fb_addr, fb_data
    );

    modport slave (
        output start, pos_x, pos_y, flip_x, rom_q,
        input  busy, done, rom_address, fb_we, fb_addr, fb_data
    );
endinterface

// File: rtl/sprite_fb_blitter.sv
// sprite_fb_blitter: copies a palettized sprite ROM into the indexed frame buffer, one pixel per clock,
// skipping transparent pixels and clipping off-screen ones, with optional horizontal mirroring.
module sprite_fb_blitter #(
    parameter int SPR_W      = 54,
    parameter int SPR_H      = 160,
    parameter int FB_W       = 320,
    parameter int FB_H       = 240,
    parameter int IDX_W      = 3,
    parameter int TRANSP_IDX = 0
) (
    input logic                  vga_clk,
    input logic                  reset_n,
    sprite_fb_blitter_if.master  bus
);
    localparam int XW = $clog2(SPR_W);
    localparam int YW = $clog2(SPR_H);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t        state, state_nx;
    logic [XW-1:0] sx, nsx;
    logic [YW-1:0] sy, nsy;
    logic [9:0]    px, py;
    logic          flip, nflip, drn, last, v1, wr;
    logic [10:0]   fx1, fy1;
    logic [13:0]   addr_nx;

    assign last     = sx == XW'(SPR_W-1) && sy == YW'(SPR_H-1);
    assign bus.busy = state == RUN || state == DRAIN;
    assign bus.done = state == DONE;
    // fx1/fy1 belong to the pixel whose ROM data is on rom_q this cycle
    assign wr = v1 && bus.rom_q != IDX_W'(TRANSP_IDX) && fx1 < 11'(FB_W) && fy1 < 11'(FB_H);

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    state_nx = bus.start ? RUN : IDLE;
            RUN:     state_nx = last ? DRAIN : RUN;
            DRAIN:   state_nx = drn ? DONE : DRAIN;
            default: state_nx = IDLE;
        endcase
        nsx     = (state != RUN || sx == XW'(SPR_W-1)) ? '0 : sx + XW'(1);
        nsy     = state != RUN ? '0 : (sx == XW'(SPR_W-1) ? sy + YW'(1) : sy);
        nflip   = state == IDLE ? bus.flip_x : flip;
        addr_nx = 14'(int'(nsy) * SPR_W + (nflip ? SPR_W - 1 - int'(nsx) : int'(nsx)));
    end

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            sx              <= '0;
            sy              <= '0;
            px              <= '0;
            py              <= '0;
            flip            <= 1'b0;
            drn             <= 1'b0;
            v1              <= 1'b0;
            fx1             <= '0;
            fy1             <= '0;
            bus.rom_address <= '0;
            bus.fb_we       <= 1'b0;
            bus.fb_addr     <= '0;
            bus.fb_data     <= '0;
        end else begin
            if (state == IDLE && bus.start) begin
                px   <= bus.pos_x;
                py   <= bus.pos_y;
                flip <= bus.flip_x;
            end
            sx  <= nsx;
            sy  <= nsy;
            drn <= state == DRAIN && !drn;
            if (state_nx == RUN) bus.rom_address <= addr_nx;
            v1        <= state == RUN;
            fx1       <= 11'(px) + 11'(sx);
            fy1       <= 11'(py) + 11'(sy);
            bus.fb_we <= wr;
            // address formed at full width; bounds check guarantees it fits after truncation
            if (wr) begin
                bus.fb_addr <= 17'(21'(fy1) * 21'(FB_W) + 21'(fx1));
                bus.fb_data <= bus.rom_q;
            end
        end
    end
endmodule

// File: tb/tb_sprite_fb_blitter.sv
// tb_sprite_fb_blitter: hand-computed blit vectors plus randomized blits checked against a pixel-walk model.
module tb_sprite_fb_blitter;
    logic vga_clk;
    logic reset_n;

    sprite_fb_blitter_if #(.IDX_W(3)) bus ();

    sprite_fb_blitter dut (
        .vga_clk (vga_clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct {
        int addr;
        int data;
    } wr_t;

    typedef struct {
        logic [9:0] px;
        logic [9:0] py;
        logic       f;
        int         nwr;
        int         first_a;
        int         first_d;
    } vec_t;

    logic [2:0] rom [0:16383];
    int         exp_a [0:8639];
    wr_t        exp_w [$];
    int         exp_n;
    int n_chk, n_fail;
    int r_nwr, r_fa, r_fd, r_done_c, r_done_n, r_busy, r_aerr, r_werr, r_oob;
    vec_t vecs [6];

    initial begin
        vga_clk = 1'b0;
        forever #5 vga_clk = ~vga_clk;
    end

    always @(posedge vga_clk) bus.rom_q <= rom[bus.rom_address];

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic fill_rom(input bit rnd);
        for (int i = 0; i < 16384; i++) rom[i] = (i < 8640) ? (rnd ? 3'($urandom) : 3'(i % 8)) : 3'd0;
    endtask

    // Walk the sprite in raster order, deriving the ROM address and every visible, opaque write.
    task automatic build_model(input int px, input int py, input bit f);
        exp_w.delete();
        for (int y = 0; y < 160; y++)
            for (int x = 0; x < 54; x++) begin
                int a;
                a = y * 54 + (f ? 53 - x : x);
                exp_a[y * 54 + x] = a;
                if (rom[a] != 3'd0 && px + x < 320 && py + y < 240)
                    exp_w.push_back('{addr: (py + y) * 320 + px + x, data: int'(rom[a])});
            end
        exp_n = exp_w.size();
    endtask

    task automatic blit(input logic [9:0] px, input logic [9:0] py, input logic f, input int glitch);
        build_model(int'(px), int'(py), f);
        r_nwr = 0; r_fa = -1; r_fd = -1; r_done_c = -1; r_done_n = 0;
        r_busy = 0; r_aerr = 0; r_werr = 0; r_oob = 0;
        bus.pos_x = px; bus.pos_y = py; bus.flip_x = f; bus.start = 1'b1;
        @(negedge vga_clk);
        bus.start = 1'b0; bus.pos_x = 10'($urandom); bus.pos_y = 10'($urandom); bus.flip_x = ~f;
        for (int c = 1; c <= 8650; c++) begin
            if (bus.busy) r_busy++;
            if (bus.done) begin
                r_done_n++;
                if (r_done_c < 0) r_done_c = c;
            end
            if (c <= 8640 && int'(bus.rom_address) != exp_a[c-1]) r_aerr++;
            if (bus.fb_we) begin
                r_nwr++;
                if (bus.fb_addr >= 17'd76800) r_oob++;
                if (r_nwr == 1) begin
                    r_fa = int'(bus.fb_addr);
                    r_fd = int'(bus.fb_data);
                end
                if (exp_w.size() == 0 || exp_w[0].addr != int'(bus.fb_addr) || exp_w[0].data != int'(bus.fb_data))
                    r_werr++;
                else
                    void'(exp_w.pop_front());
            end
            bus.start = (c == glitch);
            @(negedge vga_clk);
        end
        r_werr += exp_w.size();
    endtask

    task automatic chk_common(input string tag);
        chk({tag, " write_seq_errors"}, r_werr, 0);
        chk({tag, " rom_addr_errors"}, r_aerr, 0);
        chk({tag, " out_of_range_writes"}, r_oob, 0);
        chk({tag, " busy_cycles"}, r_busy, 8642);
        chk({tag, " done_cycle"}, r_done_c, 8643);
        chk({tag, " done_pulses"}, r_done_n, 1);
    endtask

    initial begin
        int k;
        n_chk = 0; n_fail = 0;
        vecs[0] = '{px: 10'd0,   py: 10'd0,   f: 1'b0, nwr: 7560, first_a: 1,     first_d: 1};
        vecs[1] = '{px: 10'd300, py: 10'd200, f: 1'b0, nwr: 700,  first_a: 64301, first_d: 1};
        vecs[2] = '{px: 10'd10,  py: 10'd5,   f: 1'b1, nwr: 7560, first_a: 1610,  first_d: 5};
        vecs[3] = '{px: 10'd320, py: 10'd240, f: 1'b0, nwr: 0,    first_a: -1,    first_d: -1};
        vecs[4] = '{px: 10'd0,   py: 10'd239, f: 1'b0, nwr: 47,   first_a: 76481, first_d: 1};
        vecs[5] = '{px: 10'd319, py: 10'd0,   f: 1'b1, nwr: 160,  first_a: 319,   first_d: 5};
        fill_rom(1'b0);

        reset_n = 1'b0; bus.start = 1'b1; bus.pos_x = '0; bus.pos_y = '0; bus.flip_x = 1'b0;
        repeat (3) @(negedge vga_clk);
        chk("reset busy", bus.busy, 0);
        chk("reset done", bus.done, 0);
        chk("reset fb_we", bus.fb_we, 0);
        chk("reset rom_address", bus.rom_address, 0);
        chk("reset fb_addr", bus.fb_addr, 0);
        chk("reset fb_data", bus.fb_data, 0);
        reset_n = 1'b1;
        @(negedge vga_clk);
        chk("first edge accept busy", bus.busy, 1);
        reset_n = 1'b0; bus.start = 1'b0;
        @(negedge vga_clk);
        reset_n = 1'b1;
        @(negedge vga_clk);

        for (int i = 0; i < 6; i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            blit(vecs[i].px, vecs[i].py, vecs[i].f, 0);
            chk({tag, " writes"}, r_nwr, vecs[i].nwr);
            chk({tag, " first_addr"}, r_fa, vecs[i].first_a);
            chk({tag, " first_data"}, r_fd, vecs[i].first_d);
            chk_common(tag);
        end

        fill_rom(1'b1);
        blit(10'($urandom_range(0, 400)), 10'($urandom_range(0, 300)), 1'($urandom), 2000);
        chk("midstart writes", r_nwr, exp_n);
        chk_common("midstart");

        fill_rom(1'b0);
        bus.pos_x = '0; bus.pos_y = '0; bus.flip_x = 1'b0; bus.start = 1'b1;
        @(negedge vga_clk);
        bus.start = 1'b0;
        repeat (1000) @(negedge vga_clk);
        chk("abort we_before", bus.fb_we, 1);
        chk("abort rom_address_before", bus.rom_address, 1000);
        reset_n = 1'b0;
        #1;
        chk("abort fb_we", bus.fb_we, 0);
        chk("abort busy", bus.busy, 0);
        chk("abort rom_address", bus.rom_address, 0);
        k = 0;
        repeat (3) begin
            @(negedge vga_clk);
            k += int'(bus.done) + int'(bus.fb_we) + int'(bus.busy);
        end
        reset_n = 1'b1;
        repeat (20) begin
            @(negedge vga_clk);
            k += int'(bus.done) + int'(bus.fb_we) + int'(bus.busy);
        end
        chk("abort activity_after", k, 0);

        fill_rom(1'b1);
        blit(10'($urandom_range(0, 400)), 10'($urandom_range(0, 300)), 1'($urandom), 0);
        chk("post_abort writes", r_nwr, exp_n);
        chk_common("post_abort");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
